inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the RISC-V pipeline. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. It buffers returned instructions with their PCs in a small FIFO and presents them to decode, where the instruction word feeds the immediate generator. It also accepts PC redirects from the branch/jump resolution logic, whose target is PC plus the generated immediate, and discards in-flight fetches from the wrong path.

## Interface
- DEPTH, 2: FIFO entries; also the maximum number of requests outstanding plus buffered (power of two, ≥2).
- RESET_PC, 32'h0000_0000: PC after reset.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address (current PC).
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req).
- imem_rvalid  in  1  response valid; one per accepted request, in order, latency ≥1 cycle.
- imem_rdata  in  32  response instruction word.
- redirect  in  1  PC redirect (taken branch / jump).
- redirect_pc  in  32  redirect target.
- id_valid  out  1  decode entry available.
- id_ready  in  1  decode accepts entry.
- id_inst  out  32  instruction word to decode.
- id_pc  out  32  PC of id_inst.
- id_misaligned  out  1  present only with IF_MISALIGN_CHECK_EN.

## Operation
- State machine states:
  - FETCH: issues requests.
  - FLUSH: discards stale responses.
  - HALT: fetch stopped after a misaligned redirect; reachable only with the macro.
- Counters:
  - outstanding: requests granted with no response yet.
  - drop: responses still to discard.
- Issue rule: imem_req = (state==FETCH) && (outstanding + fifo_count < DEPTH) && !redirect. imem_addr = pc.
- On imem_req && imem_gnt: pc <= pc + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0); outstanding++.
- On imem_rvalid:
  - If drop == 0, push {pc_of_request, imem_rdata}. The request PCs are held in a parallel DEPTH-entry queue.
  - If drop > 0, decrement drop and do not push.
- Pop when id_valid && id_ready. id_valid = FIFO not empty. id_inst/id_pc show the head entry.
- Redirect, highest priority, same cycle:
  - FIFO cleared; any push that cycle is dropped; pop ignored.
  - drop <= outstanding + (gnt this cycle) − (rvalid this cycle).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Next state: FLUSH if the new drop > 0, else FETCH.
- FLUSH → FETCH when drop reaches 0. No requests are issued in FLUSH.
- A redirect during FLUSH recomputes drop with the same rule.
- Simultaneous push and pop on a full FIFO is legal. The credit rule prevents overflow; overflow is a verification assertion.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0.
  - id_misaligned=0; state=FETCH; counters=0.
- First imem_req is in the first cycle after reset deasserts.
- Response to decode: id_valid rises the cycle after imem_rvalid, because the FIFO write is registered (no bypass).
- Redirect at cycle N: imem_req=0 at N. The first request to the target is at N+1 if nothing is in flight.
- Decode stall (id_ready=0): the FIFO fills and issue stops; no entry is lost or duplicated.
- Reset asserted mid-operation clears everything immediately. Responses arriving after reset release are not tracked; memory is required to be reset together with this stage.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 enters HALT after draining (drop handling as above).
  - It enqueues one entry {pc=redirect_pc, inst=NOP, misaligned=1}.
  - No further requests are issued until the next aligned redirect.
  - id_misaligned is driven from the head entry.
- Undefined: the port is absent, the low two bits are silently cleared, and no HALT state exists.

## Structure
- Package fetch_pkg holds:
  - RESET_PC default.
  - NOP_INST = 32'h0000_0013.
  - typedef fetch_entry_t {pc, inst, misaligned}.
  - state enum.
- Sub-module fetch_fifo: parameterised DEPTH synchronous FIFO of fetch_entry_t with push, pop, clear, count, full and empty.

## Test plan
- Reset release, imem always grants, 1-cycle response: addresses 0,4,8,… issued. Decode sees pc 0,4,8 with matching words, one per cycle in steady state.
- id_ready held 0 for 10 cycles: at most DEPTH entries buffered, imem_req drops. On release, entries are drained in order with no gaps or duplicates.
- Redirect to 32'h100 with 2 requests outstanding: both responses discarded, FLUSH for 2 responses. Next request addr 32'h100; first id_pc 32'h100.
- Redirect in the same cycle as imem_rvalid and pop: FIFO empty next cycle, drop count correct, no stale entry reaches decode.
- PC at 32'hFFFF_FFFC granted: next imem_addr is 32'h0.
- With IF_MISALIGN_CHECK_EN, redirect to 32'h102: one entry with id_misaligned=1, id_pc=32'h102, id_inst=NOP, then no requests until redirect to 32'h200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// IF_MISALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misaligned;
    } fetch_entry_t;

`ifdef IF_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1
    } fetch_state_t;
`endif

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; head is read combinationally
// from the storage registers so decode sees an entry the cycle after it is written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, inst: NOP_INST, misaligned: 1'b0};
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, wrong-path flush.
// Optional IF_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        id_misaligned
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [31:0]   pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] out_nxt_s;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] drop_nxt_s;
    logic [31:0]   reqpc_r [DEPTH];
    logic [PW-1:0] rq_wr_r;
    logic [PW-1:0] rq_rd_r;
    logic          fire_s;
    logic          credit_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  push_data_s;
    fetch_entry_t  head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
`ifdef IF_MISALIGN_CHECK_EN
    logic          halt_pend_r;
    logic          halt_pend_nxt_s;
    logic [31:0]   halt_pc_r;
    logic          halt_push_s;
`else
    logic          unused_bits_s;
`endif

    assign credit_s  = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CW+1)'(DEPTH);
    assign imem_req  = !reset && (state_r == FETCH) && credit_s && !redirect;
    assign imem_addr = pc_r;
    assign fire_s    = imem_req && imem_gnt;
    assign out_nxt_s = outstanding_r + CW'(fire_s) - CW'(imem_rvalid);
    assign pop_s     = id_valid && id_ready && !redirect;

    assign id_valid  = !fifo_empty_s;
    assign id_inst   = head_s.inst;
    assign id_pc     = head_s.pc;
`ifdef IF_MISALIGN_CHECK_EN
    assign id_misaligned = head_s.misaligned;
    assign halt_push_s   = (state_r == HALT) && halt_pend_r && !redirect;
`else
    assign unused_bits_s = &{1'b0, head_s.misaligned, fifo_full_s, redirect_pc[1:0]};
`endif

    // Response push selection; the halt marker entry takes the push slot when pending.
    always_comb begin
        push_s      = imem_rvalid && (drop_r == '0) && !redirect;
        push_data_s = '{pc: reqpc_r[rq_rd_r], inst: imem_rdata, misaligned: 1'b0};
`ifdef IF_MISALIGN_CHECK_EN
        if (halt_push_s) begin
            push_s      = 1'b1;
            push_data_s = '{pc: halt_pc_r, inst: NOP_INST, misaligned: 1'b1};
        end else begin
            push_s      = push_s;
            push_data_s = push_data_s;
        end
`endif
    end

    // Drop count and next state; a redirect snapshots every response still in flight.
    always_comb begin
        state_nxt_s = state_r;
`ifdef IF_MISALIGN_CHECK_EN
        halt_pend_nxt_s = halt_pend_r;
`endif
        if (redirect) begin
            drop_nxt_s = out_nxt_s;
        end else if (imem_rvalid && (drop_r != '0)) begin
            drop_nxt_s = drop_r - CW'(1);
        end else begin
            drop_nxt_s = drop_r;
        end

        if (redirect) begin
`ifdef IF_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_nxt_s     = (drop_nxt_s != '0) ? FLUSH : HALT;
                halt_pend_nxt_s = 1'b1;
            end else begin
                state_nxt_s     = (drop_nxt_s != '0) ? FLUSH : FETCH;
                halt_pend_nxt_s = 1'b0;
            end
`else
            state_nxt_s = (drop_nxt_s != '0) ? FLUSH : FETCH;
`endif
        end else begin
            case (state_r)
                FETCH: state_nxt_s = FETCH;
                FLUSH: begin
                    if (drop_nxt_s == '0) begin
`ifdef IF_MISALIGN_CHECK_EN
                        state_nxt_s = halt_pend_r ? HALT : FETCH;
`else
                        state_nxt_s = FETCH;
`endif
                    end else begin
                        state_nxt_s = FLUSH;
                    end
                end
`ifdef IF_MISALIGN_CHECK_EN
                HALT: begin
                    state_nxt_s     = HALT;
                    halt_pend_nxt_s = halt_push_s ? 1'b0 : halt_pend_r;
                end
`endif
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // FSM, PC, counters and the request-PC queue that pairs responses with addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            outstanding_r <= '0;
            drop_r        <= '0;
            rq_wr_r       <= '0;
            rq_rd_r       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reqpc_r[i] <= 32'h0000_0000;
            end
`ifdef IF_MISALIGN_CHECK_EN
            halt_pend_r <= 1'b0;
            halt_pc_r   <= 32'h0000_0000;
`endif
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= out_nxt_s;
            drop_r        <= drop_nxt_s;
            if (redirect) begin
                pc_r <= word_align(redirect_pc);
            end else if (fire_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (fire_s) begin
                reqpc_r[rq_wr_r] <= pc_r;
                rq_wr_r          <= rq_wr_r + PW'(1);
            end
            if (imem_rvalid) begin
                rq_rd_r <= rq_rd_r + PW'(1);
            end
`ifdef IF_MISALIGN_CHECK_EN
            halt_pend_r <= halt_pend_nxt_s;
            if (redirect) begin
                halt_pc_r <= redirect_pc;
            end
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .clear     (redirect),
        .head      (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed phases plus random traffic against a
// transaction-level model of the expected fetch and decode streams.
module tb_inst_fetch;

    localparam int          DEPTH_TB = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic        id_misaligned;
`endif

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          gnt_pct;
    int          rdy_pct;
    int          lat_min;
    int          lat_max;
    int          pop_cnt;
    int          buffered;
    int          stale;
    bit          halted;
    bit          seen_wrap;
    bit          found;
    logic [31:0] exp_fetch;
    logic [31:0] exp_id_pc;
    logic [31:0] prev_gnt_addr;
    logic [31:0] tgt;
    req_t        memq[$];

    inst_fetch #(
        .DEPTH    (DEPTH_TB),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .id_misaligned (id_misaligned)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        memq.delete();
        exp_fetch     = 32'h0;
        exp_id_pc     = 32'h0;
        prev_gnt_addr = 32'h0;
        buffered      = 0;
        stale         = 0;
        halted        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
        chk("rst_id_misaligned", 32'(id_misaligned), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input logic redir, input logic [31:0] target);
        logic rsp;
        logic gnt;
        logic pop;
        logic exp_req;
        req_t dmy;
        @(negedge clk);
        redirect    = redir;
        redirect_pc = target;
        id_ready    = ($urandom_range(99) < rdy_pct);
        imem_gnt    = 1'b0;
        rsp         = (memq.size() > 0) && (memq[0].due <= cyc);
        if (rsp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        exp_req = !redir && !halted && (stale == 0) && ((memq.size() + buffered) < DEPTH_TB);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (!halted) chk("id_valid", 32'(id_valid), 32'(buffered > 0));
        gnt = imem_req && ($urandom_range(99) < gnt_pct);
        imem_gnt = gnt;
        if (gnt) begin
            chk("imem_addr", imem_addr, exp_fetch);
            if (prev_gnt_addr == 32'hFFFF_FFFC && imem_addr == 32'h0) seen_wrap = 1'b1;
            prev_gnt_addr = imem_addr;
            memq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            exp_fetch = exp_fetch + 32'd4;
        end
        pop = id_valid && id_ready && !redir;
        if (pop) begin
            chk("id_pc", id_pc, exp_id_pc);
            if (halted) begin
                chk("halt_id_inst", id_inst, NOP);
`ifdef IF_MISALIGN_CHECK_EN
                chk("halt_misaligned", 32'(id_misaligned), 32'd1);
`endif
            end else begin
                chk("id_inst", id_inst, word_of(exp_id_pc));
`ifdef IF_MISALIGN_CHECK_EN
                chk("id_misaligned", 32'(id_misaligned), 32'd0);
`endif
                buffered--;
                exp_id_pc = exp_id_pc + 32'd4;
            end
            pop_cnt++;
        end
        if (rsp) begin
            dmy = memq.pop_front();
            if (stale > 0) stale--;
            else if (!redir) buffered++;
        end
        if (redir) begin
            buffered  = 0;
            stale     = memq.size();
            exp_fetch = {target[31:2], 2'b00};
            exp_id_pc = exp_fetch;
            halted    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
                halted    = 1'b1;
                exp_id_pc = target;
            end
`endif
        end
        cyc++;
    endtask

    initial begin
        clk = 1'b0;
        n_chk = 0; n_fail = 0; cyc = 0; pop_cnt = 0; seen_wrap = 1'b0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();

        // Streaming with immediate grant and 1-cycle latency.
        repeat (10) step(1'b0, 32'h0);
        pop_cnt = 0;
        repeat (20) step(1'b0, 32'h0);
        chk("steady_rate", 32'(pop_cnt), 32'd20);

        // Decode stall then release.
        rdy_pct = 0;
        repeat (10) step(1'b0, 32'h0);
        chk("stall_valid", 32'(id_valid), 32'd1);
        chk("stall_noreq", 32'(imem_req), 32'd0);
        rdy_pct = 100;
        repeat (10) step(1'b0, 32'h0);

        // Redirect with exactly two responses outstanding.
        lat_min = 3; lat_max = 3; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() == 2 && memq[0].due > cyc) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        chk("setup_two_outstanding", 32'(found), 32'd1);
        step(1'b1, 32'h0000_0100);
        lat_min = 1; lat_max = 1;
        repeat (15) step(1'b0, 32'h0);

        // Redirect in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc && buffered > 0) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        chk("setup_rsp_pop", 32'(found), 32'd1);
        step(1'b1, 32'h0000_0300);
        repeat (10) step(1'b0, 32'h0);

        // PC wrap-around at the top of the address space.
        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step(1'b0, 32'h0);
        chk("wrap_seen", 32'(seen_wrap), 32'd1);

`ifndef IF_MISALIGN_CHECK_EN
        step(1'b1, 32'h0000_010A);
        repeat (10) step(1'b0, 32'h0);
`endif

        // Random traffic with occasional redirects.
        gnt_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
        repeat (400) begin
            if ($urandom_range(99) < 4) begin
                tgt = $urandom();
`ifdef IF_MISALIGN_CHECK_EN
                tgt = tgt & 32'hFFFF_FFFC;
`endif
                step(1'b1, tgt);
            end else begin
                step(1'b0, 32'h0);
            end
        end

        // Reset in the middle of traffic.
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 2;
        repeat (15) step(1'b0, 32'h0);

`ifdef IF_MISALIGN_CHECK_EN
        // Misaligned redirect halts fetch until an aligned redirect.
        rdy_pct = 0;
        step(1'b1, 32'h0000_0102);
        for (int i = 0; i < 20 && !id_valid; i++) step(1'b0, 32'h0);
        chk("halt_entry_valid", 32'(id_valid), 32'd1);
        chk("halt_entry_misaligned", 32'(id_misaligned), 32'd1);
        chk("halt_entry_pc", id_pc, 32'h0000_0102);
        chk("halt_entry_inst", id_inst, NOP);
        rdy_pct = 100;
        repeat (10) step(1'b0, 32'h0);
        chk("halt_drained", 32'(id_valid), 32'd0);
        step(1'b1, 32'h0000_0200);
        repeat (15) step(1'b0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
